// File: rtl/cpu32b_pkg.sv
// Shared definitions for the 32-bit core front end: data width, fetch defaults
// and the {pc, instr} entry carried through the fetch queue.
package cpu32b_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam int              IMEM_WORDS_DEF = 64;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched {pc, instr} pairs with synchronous flush.
// The caller never pushes into a full queue without a same-cycle pop, nor pops an empty one.
module fetch_fifo
    import cpu32b_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) entries[wr_ptr] <= din;
    end

    assign dout  = entries[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, redirect handling and a 2-entry fetch queue.
// Optional out-of-range fetch detection is enabled by defining IFETCH_BOUND_CHK_EN.
module ifetch_unit
    import cpu32b_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int              IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            fetch_fault
);

    logic [XLEN-1:0] pc;
    logic            fault;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            can_fetch;
    logic            in_range;
    fetch_entry_t    head;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

`ifdef IFETCH_BOUND_CHK_EN
    assign in_range = ({2'b00, pc[XLEN-1:2]} < XLEN'(IMEM_WORDS));
`else
    assign in_range = 1'b1;
`endif

    assign out_valid = !fifo_empty && !redirect_valid && !reset;
    assign pop       = out_valid && out_ready;
    assign can_fetch = !redirect_valid && !fault && (!fifo_full || pop);
    assign push      = can_fetch && in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= {RESET_PC[XLEN-1:2], 2'b00};
            fault <= 1'b0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            fault <= 1'b0;
        end else if (push) begin
            pc    <= pc + XLEN'(4);
        end else if (can_fetch) begin
            // Only reachable when the range check rejects the fetch; the fault stops further fetches.
            fault <= 1'b1;
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({pc, imem_rdata}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign imem_addr   = pc;
    assign out_instr   = head.instr;
    assign out_pc      = head.pc;
    assign fetch_fault = fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a queue-based fetch model pushes expected entries,
// a monitor pops and compares them whenever decode accepts an instruction.
module tb_ifetch_unit;
    import cpu32b_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          WORDS  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    logic [31:0] mem [WORDS];

    fetch_entry_t exp_q [$];
    logic [31:0]  m_pc    = RST_PC;
    logic         m_fault = 1'b0;
    bit           acc     = 1'b0;
    bit           mon_en  = 1'b0;
    int           checks  = 0;
    int           passes  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if ((a >> 2) < WORDS) return mem[int'(a >> 2)];
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = word_at(imem_addr);

    ifetch_unit #(.RESET_PC(RST_PC), .IMEM_WORDS(WORDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare what decode sees against the head of the expected stream.
    always @(negedge clk) begin
        acc = 1'b0;
        if (mon_en) begin
            logic exp_v;
            exp_v = (exp_q.size() > 0) && !redirect_valid && !reset;
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
            check("imem_addr", imem_addr, m_pc);
            check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
            if (exp_v) begin
                check("out_pc", out_pc, exp_q[0].pc);
                check("out_instr", out_instr, exp_q[0].instr);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    acc = 1'b1;
                end
            end
        end
    end

    // Reference model: decides what the coming clock edge fetches and queues it as expected output.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            exp_q.delete();
            m_pc    = RST_PC;
            m_fault = 1'b0;
        end else if (redirect_valid) begin
            exp_q.delete();
            m_pc    = redirect_pc & 32'hFFFF_FFFC;
            m_fault = 1'b0;
        end else if (!m_fault && ((exp_q.size() + int'(acc)) < 2 || acc)) begin
            bit ok;
`ifdef IFETCH_BOUND_CHK_EN
            ok = (m_pc >> 2) < WORDS;
`else
            ok = 1'b1;
`endif
            if (ok) begin
                exp_q.push_back({m_pc, word_at(m_pc)});
                m_pc = m_pc + 32'd4;
            end else begin
                m_fault = 1'b1;
            end
        end
    end

    task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(1, 0, 0, 0);

        // Streaming with decode always ready.
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);

        // Back-pressure right after reset, then release.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        check("stall_imem_addr", imem_addr, 32'h8);
        check("stall_out_pc", out_pc, 32'h0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

        // Redirect to an unaligned target while the queue is full.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h22, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

        // Reset wins over a redirect and a pending handshake.
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);
        cyc(1, 1, 32'h40, 1);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

        // PC wraps modulo 2^32.
        cyc(0, 1, 32'hFFFF_FFF9, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

`ifdef IFETCH_BOUND_CHK_EN
        cyc(0, 1, 32'hF8, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        check("bound_fault", {31'b0, fetch_fault}, 32'h1);
        check("bound_imem_addr", imem_addr, 32'h100);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h0, 1);
        check("bound_fault_clr", {31'b0, fetch_fault}, 32'h0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        rv;
            logic [31:0] rpc;
            logic        rdy;
            r   = ($urandom_range(199) == 0);
            rv  = ($urandom_range(15) == 0);
            rpc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                           : 32'($urandom_range(WORDS * 4 + 24));
            rdy = ($urandom_range(3) != 0);
            cyc(r, rv, rpc, rdy);
        end

        cyc(0, 0, 0, 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 64, number of 32-bit words in instruction memory.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  32  byte address to instruction memory; equals the PC register.
REQ-006 SHALL have port imem_rdata  input  32  instruction word returned combinationally for imem_addr.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken; redirect this cycle.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port out_valid  output  1  out_instr/out_pc hold a valid fetched instruction.
REQ-010 SHALL have port out_ready  input  1  decode accepts the head entry.
REQ-011 SHALL have port out_instr  output  32  head-of-queue instruction.
REQ-012 SHALL have port out_pc  output  32  byte address of out_instr.
REQ-013 SHALL have port fetch_fault  output  1  sticky out-of-range fetch flag (see Configuration).

Function
REQ-014 SHALL hold a 2-entry FIFO of {pc, instr}; count in {0,1,2}.
REQ-015 SHALL enqueue {pc, imem_rdata} and advance pc by 4 in a cycle iff not redirect_valid, not faulted, and (count<2 or a dequeue occurs the same cycle).
REQ-016 SHALL dequeue the head when out_valid && out_ready; enqueue and dequeue in the same cycle leave count unchanged.
REQ-017 SHALL drive out_valid = (count>0) && !redirect_valid; out_instr/out_pc SHALL reflect the head and be stable while out_valid && !out_ready.
REQ-018 On redirect_valid SHALL, at the next edge, flush the FIFO (count=0), load pc = {redirect_pc[31:2],2'b00}, clear fetch_fault; no enqueue and no dequeue occur in the redirect cycle.
REQ-019 First instruction from a redirect target SHALL appear with out_valid=1 one cycle after the redirect cycle.
REQ-020 pc arithmetic SHALL be 32-bit modulo 2^32; pc[1:0] SHALL always be 0.
REQ-021 With a full FIFO and out_ready=0, pc and FIFO contents SHALL hold.

Reset
REQ-022 While reset=1 at a clock edge SHALL set pc=RESET_PC, count=0, fetch_fault=0; reset SHALL override redirect_valid and any in-flight handshake.
REQ-023 During and immediately after reset, out_valid SHALL be 0; the first entry (pc=RESET_PC) SHALL be valid in the cycle after the first non-reset edge.

Configuration
REQ-024 With IFETCH_BOUND_CHK_EN defined, when an enqueue would occur with (pc>>2) >= IMEM_WORDS, SHALL not enqueue, SHALL not advance pc, and SHALL set fetch_fault=1, held until reset or redirect; queued entries still drain.
REQ-025 Without IFETCH_BOUND_CHK_EN, fetch_fault SHALL be constant 0 and pc SHALL advance without range checking.

Structure
REQ-026 Shared package cpu32b_pkg SHALL hold XLEN=32, RESET_PC default, IMEM_WORDS default, and the fetch-entry {pc, instr} typedef.
REQ-027 The 2-entry queue SHALL be a sub-module fetch_fifo (push/pop/flush, full/empty); PC and fault logic stay in ifetch_unit.

Verification
REQ-028 Reset, then out_ready=1 constantly -> out_pc sequence 0x0,0x4,0x8 on consecutive cycles, out_instr = memory words 0,1,2.
REQ-029 out_ready=0 for 5 cycles after reset -> count reaches 2, imem_addr holds 0x8, out_pc holds 0x0; release -> 0x0,0x4,0x8 with no gaps or duplicates.
REQ-030 redirect_valid=1, redirect_pc=0x22 while FIFO full -> out_valid=0 that cycle, next cycle out_pc=0x20, prior entries never accepted.
REQ-031 reset asserted while out_valid=1 and redirect_valid=1 -> next cycle pc=RESET_PC, out_valid=0, fetch_fault=0.
REQ-032 IFETCH_BOUND_CHK_EN defined, IMEM_WORDS=64, redirect to 0xF8 with out_ready=1 -> out_pc 0xF8,0xFC then fetch_fault=1, imem_addr holds 0x100, out_valid=0; redirect to 0x0 clears fault.
